imem_loader: RTL and testbench

//  Programming controller for the instruction memory write port. Receives a framed byte

---
 rtl/imem_loader.sv | 215 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Framed byte-stream loader that packs LE words into instruction
//            memory, verifies an 8-bit checksum and gates core reset.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int          INST_MEMORY_SIZE = 16384,
    parameter int          ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
    parameter logic [7:0]  MAGIC            = 8'hA5,
    parameter int          TIMEOUT_CYCLES   = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  imem_wen,
    output logic                  cpu_hold,
    output logic                  load_busy,
    output logic                  load_ok,
    output logic                  load_err,
    output logic [1:0]            err_code
);

    localparam int          c_TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] c_MAX_WORDS = 17'(INST_MEMORY_SIZE / 4);
    localparam logic [c_TW-1:0] c_TIMEOUT_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_PASS   = 3'd5,
        S_FAIL   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_ready;
    logic [15:0]       r_cnt;
    logic [15:0]       r_idx;
    logic [1:0]        r_lane;
    logic [23:0]       r_word;
    logic [7:0]        r_sum;
    logic [c_TW-1:0]   r_timer;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_wen;
    logic              r_hold;
    logic              r_busy;
    logic              r_ok;
    logic              r_err;
    logic [1:0]        r_code;

    logic              w_accept;
    logic              w_in_frame;
    logic              w_timeout;
    logic [15:0]       w_n;
    logic              w_start;
    logic              w_pass;
    logic              w_fail;
    logic [1:0]        w_code;
    logic              w_word_done;

    assign w_accept   = in_valid && r_ready;
    assign w_in_frame = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CHECK);
    assign w_timeout  = w_in_frame && !w_accept && (r_timer == c_TIMEOUT_LAST);
    assign w_n        = {in_data, r_cnt[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_pass      = 1'b0;
        w_fail      = 1'b0;
        w_code      = 2'b00;
        w_word_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && in_data == MAGIC) begin
                    w_next  = S_CNT_LO;
                    w_start = 1'b1;
                end
            end
            S_CNT_LO: begin
                if (w_accept) w_next = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (w_accept) begin
                    if ({1'b0, w_n} > c_MAX_WORDS) begin
                        w_fail = 1'b1;
                        w_code = 2'b01;
                    end else if (w_n == 16'd0) begin
                        w_next = S_CHECK;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && r_lane == 2'd3) begin
                    w_word_done = 1'b1;
                    if (r_idx == r_cnt - 16'd1) w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_accept) begin
                    if (in_data == r_sum) begin
                        w_pass = 1'b1;
                    end else begin
                        w_fail = 1'b1;
                        w_code = 2'b10;
                    end
                end
            end
            S_PASS:  w_next = S_IDLE;
            S_FAIL:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_fail = 1'b1;
            w_code = 2'b11;
        end
        if (w_fail) w_next = S_FAIL;
        if (w_pass) w_next = S_PASS;
    end

    // Status flags change on the same edge the FSM enters PASS/FAIL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_lane  <= '0;
            r_word  <= '0;
            r_sum   <= '0;
            r_timer <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_hold  <= 1'b0;
            r_busy  <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= 2'b00;
        end else begin
            r_ready <= 1'b1;
            r_wen   <= 1'b0;
            if (w_accept || !w_in_frame) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TW'(1);
            end
            if (w_start) begin
                r_hold <= 1'b1;
                r_busy <= 1'b1;
                r_ok   <= 1'b0;
                r_err  <= 1'b0;
                r_code <= 2'b00;
                r_sum  <= '0;
                r_idx  <= '0;
                r_lane <= '0;
            end
            if (w_accept && r_state == S_CNT_LO) r_cnt[7:0]  <= in_data;
            if (w_accept && r_state == S_CNT_HI) r_cnt[15:8] <= in_data;
            if (w_accept && r_state == S_DATA) begin
                r_sum  <= r_sum + in_data;
                r_lane <= r_lane + 2'd1;
                if (!w_word_done) r_word[{r_lane, 3'b000} +: 8] <= in_data;
            end
            if (w_word_done) begin
                r_wen   <= 1'b1;
                r_waddr <= {r_idx[ADDR_WIDTH-3:0], 2'b00};
                r_wdata <= {in_data, r_word};
                r_idx   <= r_idx + 16'd1;
            end
            if (w_pass) begin
                r_ok   <= 1'b1;
                r_hold <= 1'b0;
                r_busy <= 1'b0;
            end
            if (w_fail) begin
                r_err  <= 1'b1;
                r_code <= w_code;
                r_busy <= 1'b0;
            end
        end
    end

    assign in_ready   = r_ready;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign imem_wen   = r_wen;
    assign cpu_hold   = r_hold;
    assign load_busy  = r_busy;
    assign load_ok    = r_ok;
    assign load_err   = r_err;
    assign err_code   = r_code;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed frame bench for imem_loader with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    localparam int c_TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    wire         in_ready;
    wire  [13:0] imem_waddr;
    wire  [31:0] imem_wdata;
    wire         imem_wen;
    wire         cpu_hold;
    wire         load_busy;
    wire         load_ok;
    wire         load_err;
    wire  [1:0]  err_code;

    imem_loader #(
        .INST_MEMORY_SIZE (16384),
        .ADDR_WIDTH       (14),
        .MAGIC            (8'hA5),
        .TIMEOUT_CYCLES   (c_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .imem_wen   (imem_wen),
        .cpu_hold   (cpu_hold),
        .load_busy  (load_busy),
        .load_ok    (load_ok),
        .load_err   (load_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_bad = 0;
    bit ready_armed = 1'b0;
    int last_acc = 0;

    typedef struct {
        int          cy;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t        exp_q[$];
    logic [7:0] fr[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Every cycle: a write happens exactly when the model scheduled one.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cy == cyc) begin
            check("wen_expected", {31'd0, imem_wen}, 32'd1);
            check("waddr", {18'd0, imem_waddr}, exp_q[0].addr);
            check("wdata", imem_wdata, exp_q[0].data);
            void'(exp_q.pop_front());
        end else begin
            check("no_stray_wen", {31'd0, imem_wen}, 32'd0);
        end
        if (!load_err) check("err_code_clear", {30'd0, err_code}, 32'd0);
        if (ready_armed) check("in_ready_high", {31'd0, in_ready}, 32'd1);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        last_acc = cyc;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wen", {31'd0, imem_wen}, 32'd0);
        check("rst_waddr", {18'd0, imem_waddr}, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_busy", {31'd0, load_busy}, 32'd0);
        check("rst_ok", {31'd0, load_ok}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        check("rst_code", {30'd0, err_code}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        ready_armed = 1'b0;
        in_valid    = 1'b0;
        rst_n       = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", {31'd0, in_ready}, 32'd1);
        ready_armed = 1'b1;
    endtask

    // Frame-level model: derive writes and final status from the byte list.
    task automatic run_frame(input int gap);
        int          n;
        bit          ovf;
        bit          complete;
        logic [7:0]  sum;
        n        = {fr[2], fr[1]};
        ovf      = (n > 4096);
        complete = ovf ? (fr.size() == 3) : (fr.size() == 4 + 4 * n);
        sum      = 8'h00;
        for (int i = 0; i < fr.size(); i++) begin
            send(fr[i]);
            if (i == 0) begin
                check("start_busy", {31'd0, load_busy}, 32'd1);
                check("start_hold", {31'd0, cpu_hold}, 32'd1);
                check("start_ok_clr", {31'd0, load_ok}, 32'd0);
                check("start_err_clr", {31'd0, load_err}, 32'd0);
            end
            if (!ovf && i >= 3 && (i - 3) < 4 * n) begin
                sum = sum + fr[i];
                if ((i - 3) % 4 == 3)
                    exp_q.push_back('{last_acc, 32'((i - 3) / 4 * 4),
                                      {fr[i], fr[i-1], fr[i-2], fr[i-3]}});
            end
            if (gap > 0 && i < fr.size() - 1) idle(gap);
        end
        if (complete) begin
            bit good;
            good = !ovf && (fr[fr.size()-1] == sum);
            check("end_busy", {31'd0, load_busy}, 32'd0);
            check("end_ok", {31'd0, load_ok}, {31'd0, good});
            check("end_err", {31'd0, load_err}, {31'd0, !good});
            check("end_hold", {31'd0, cpu_hold}, {31'd0, !good});
            check("end_code", {30'd0, err_code}, good ? 32'd0 : (ovf ? 32'd1 : 32'd2));
        end else begin
            check("mid_busy", {31'd0, load_busy}, 32'd1);
            check("mid_err", {31'd0, load_err}, 32'd0);
        end
        idle(2);
        check("writes_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Checksum of 11 22 33 44 AA BB CC DD is 0x3B8 mod 256 = 0xB8.
        fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB8};
        run_frame(0);
        check("t1_ok_literal", {31'd0, load_ok}, 32'd1);
        check("t1_last_addr", {18'd0, imem_waddr}, 32'd4);
        check("t1_last_data", imem_wdata, 32'hDDCCBBAA);

        fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB9};
        run_frame(2);
        check("t2_code_literal", {30'd0, err_code}, 32'd2);

        fr = '{8'hA5, 8'h01, 8'h10};
        run_frame(0);
        check("t3_code_literal", {30'd0, err_code}, 32'd1);

        send(8'h00); send(8'hFF); send(8'h12);
        idle(2);
        check("junk_ignored_busy", {31'd0, load_busy}, 32'd0);
        check("junk_keeps_err", {31'd0, load_err}, 32'd1);
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(0);
        check("t4_hold_released", {31'd0, cpu_hold}, 32'd0);

        fr = '{8'hA5, 8'h01, 8'h00, 8'h11};
        run_frame(0);
        while (cyc < last_acc + c_TO - 1) @(negedge clk);
        check("t5_no_early_timeout", {31'd0, load_err}, 32'd0);
        check("t5_busy_before", {31'd0, load_busy}, 32'd1);
        @(negedge clk);
        check("t5_timeout_err", {31'd0, load_err}, 32'd1);
        check("t5_timeout_code", {30'd0, err_code}, 32'd3);
        check("t5_hold", {31'd0, cpu_hold}, 32'd1);
        check("t5_busy_after", {31'd0, load_busy}, 32'd0);

        // N = 4096 is the largest legal count; abort it mid-data with reset.
        fr = '{8'hA5, 8'h00, 8'h10, 8'h11, 8'h22};
        run_frame(0);
        do_reset();
        fr = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
        run_frame(1);
        check("t6_data_literal", imem_wdata, 32'hEFBEADDE);
        check("t6_ok_literal", {31'd0, load_ok}, 32'd1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
